// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation or vectoring mode, quadrant pre-rotation,
// residual-angle output and optional gain compensation with output saturation.
module cordic_engine #(
  parameter int WIDTH     = 16,
  parameter int FRAC      = 7,
  parameter int ITERS     = 12,
  parameter bit SCALE_EN  = 1'b1,
  parameter int GAIN      = 19898,
  parameter int GAIN_FRAC = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [15:0]      z_i,
  output logic                    ready,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [15:0]      z_o
);

  // Two guard bits cover the ~1.647 CORDIC growth and negating the most negative input.
  localparam int IW = WIDTH + 2;
  localparam int PW = IW + 17;
  localparam int CW = 4;
  localparam logic signed [15:0] HALF_PI = 16'sd12868;
  localparam logic signed [16:0] GAIN_S  = 17'(GAIN);

  if (ITERS < 4 || ITERS > 14 || FRAC < 0 || FRAC >= WIDTH) begin : g_bad_params
    $error("cordic_engine: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, SCALE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 mode_r;
  logic signed [IW-1:0] xr, yr;
  logic signed [15:0]   zr;

  function automatic logic signed [15:0] atan_lut(input logic [CW-1:0] i);
    case (i)
      4'd0:    return 16'sd6434;
      4'd1:    return 16'sd3798;
      4'd2:    return 16'sd2007;
      4'd3:    return 16'sd1019;
      4'd4:    return 16'sd511;
      4'd5:    return 16'sd256;
      4'd6:    return 16'sd128;
      4'd7:    return 16'sd64;
      4'd8:    return 16'sd32;
      4'd9:    return 16'sd16;
      4'd10:   return 16'sd8;
      4'd11:   return 16'sd4;
      4'd12:   return 16'sd2;
      4'd13:   return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (&v[PW-1:WIDTH-1] || ~|v[PW-1:WIDTH-1]) return v[WIDTH-1:0];
    else if (v[PW-1])                          return {1'b1, {(WIDTH-1){1'b0}}};
    else                                       return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Quadrant pre-rotation brings every operand into the CORDIC convergence range.
  logic signed [IW-1:0] xe, ye, px, py;
  logic signed [15:0]   pz;

  always_comb begin
    xe = {{2{x_i[WIDTH-1]}}, x_i};
    ye = {{2{y_i[WIDTH-1]}}, y_i};
    px = xe;
    py = ye;
    pz = z_i;
    if (!mode_i) begin
      if (z_i > HALF_PI) begin
        px = -ye;  py = xe;  pz = z_i - HALF_PI;
      end else if (z_i < -HALF_PI) begin
        px = ye;   py = -xe; pz = z_i + HALF_PI;
      end
    end else begin
      pz = '0;
      if (xe[IW-1]) begin
        if (!ye[IW-1]) begin
          px = ye;   py = -xe; pz = HALF_PI;
        end else begin
          px = -ye;  py = xe;  pz = -HALF_PI;
        end
      end
    end
  end

  // One micro-rotation per CALC cycle.
  logic signed [IW-1:0] xs, ys, xn, yn;
  logic signed [15:0]   zn, at;
  logic                 dpos;

  always_comb begin
    xs   = xr >>> cnt;
    ys   = yr >>> cnt;
    at   = atan_lut(cnt);
    dpos = mode_r ? yr[IW-1] : ~zr[15];
    if (dpos) begin
      xn = xr - ys;  yn = yr + xs;  zn = zr - at;
    end else begin
      xn = xr + ys;  yn = yr - xs;  zn = zr + at;
    end
  end

  logic signed [PW-1:0] xp, yp;

  always_comb begin
    if (SCALE_EN) begin
      xp = (PW'(xr) * PW'(GAIN_S)) >>> GAIN_FRAC;
      yp = (PW'(yr) * PW'(GAIN_S)) >>> GAIN_FRAC;
    end else begin
      xp = PW'(xr);
      yp = PW'(yr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      x_o    <= '0;
      y_o    <= '0;
      z_o    <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xr     <= px;
          yr     <= py;
          zr     <= pz;
          mode_r <= mode_i;
          cnt    <= '0;
          ready  <= 1'b0;
          state  <= CALC;
        end
        CALC: begin
          xr  <= xn;
          yr  <= yn;
          zr  <= zn;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= SCALE;
        end
        SCALE: begin
          x_o   <= sat(xp);
          y_o   <= sat(yp);
          z_o   <= zr;
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Bench for cordic_engine: directed and randomized operations checked against an
// ideal real-arithmetic rotation/vectoring model with error tolerances.
`timescale 1ns/1ps
module tb_cordic_engine;
  localparam int  WIDTH = 16;
  localparam int  ITERS = 12;
  localparam int  LAT   = ITERS + 2;
  localparam real ZS    = 8192.0;

  logic clk = 1'b0;
  logic reset, start, mode_i;
  logic signed [WIDTH-1:0] x_i, y_i, x_o, y_o, xr_o, yr_o;
  logic signed [15:0] z_i, z_o, zr_o;
  logic ready, done, ready_r, done_r;

  int  tests_run = 0;
  int  tests_failed = 0;
  real g_raw, g_sc;

  always #5 clk = ~clk;

  cordic_engine #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_i(mode_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .ready(ready), .done(done), .x_o(x_o), .y_o(y_o), .z_o(z_o));

  cordic_engine #(.WIDTH(WIDTH), .ITERS(ITERS), .SCALE_EN(1'b0)) dut_raw (
    .clk(clk), .reset(reset), .start(start), .mode_i(mode_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .ready(ready_r), .done(done_r), .x_o(xr_o), .y_o(yr_o), .z_o(zr_o));

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int clamp16(input int v);
    return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
  endfunction

  // Ideal rotation of (x,y) by z radians (Q3.13), times overall gain g, saturated.
  function automatic void model_rot(input int x, input int y, input int z, input real g,
                                    output int ex, output int ey);
    real th;
    th = real'(z) / ZS;
    ex = clamp16(rnd((real'(x) * $cos(th) - real'(y) * $sin(th)) * g));
    ey = clamp16(rnd((real'(x) * $sin(th) + real'(y) * $cos(th)) * g));
  endfunction

  function automatic void model_vec(input int x, input int y, input real g,
                                    output int em, output int ez);
    em = clamp16(rnd($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * g));
    ez = rnd($atan2(real'(y), real'(x)) * ZS);
  endfunction

  // Issue one operation from an idle-aligned point; lat is edges from capture to done.
  task automatic run_op(input bit m, input int x, input int y, input int z, output int lat);
    int n;
    n = 0;
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    mode_i = m; x_i = WIDTH'(x); y_i = WIDTH'(y); z_i = 16'(z); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 4 * LAT) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode_i = 1'b0; x_i = '0; y_i = '0; z_i = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (x_o !== 16'sd0 || y_o !== 16'sd0 || z_o !== 16'sd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %0d %0d %0d want 0 0 0", x_o, y_o, z_o); end
    tests_run++; if (ready_r !== 1'b1 || done_r !== 1'b0) begin
      tests_failed++; $display("FAIL reset_raw: got ready %b done %b", ready_r, done_r); end
    reset = 1'b0;
  endtask

  task automatic test_rotation_basic();
    int lat, ex, ey;
    run_op(1'b0, 128, 0, 12868, lat);
    model_rot(128, 0, 12868, g_sc, ex, ey);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL rot_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL rot_ready_at_done: got %b want 1", ready); end
    tests_run++; if (adiff(x_o, ex) > 4) begin tests_failed++; $display("FAIL rot_x: got %0d want %0d", x_o, ex); end
    tests_run++; if (adiff(y_o, ey) > 4) begin tests_failed++; $display("FAIL rot_y: got %0d want %0d", y_o, ey); end
    tests_run++; if (adiff(z_o, 0) > 4) begin tests_failed++; $display("FAIL rot_z: got %0d want 0", z_o); end
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rot_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_vectoring();
    int lat, em, ez;
    run_op(1'b1, -128, 0, 0, lat);
    model_vec(-128, 0, g_sc, em, ez);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL vec_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (adiff(x_o, em) > 4) begin tests_failed++; $display("FAIL vec_neg_mag: got %0d want %0d", x_o, em); end
    tests_run++; if (adiff(y_o, 0) > 4) begin tests_failed++; $display("FAIL vec_neg_y: got %0d want 0", y_o); end
    tests_run++; if (adiff(z_o, ez) > 12) begin tests_failed++; $display("FAIL vec_neg_phase: got %0d want %0d", z_o, ez); end
    run_op(1'b1, 384, 384, 0, lat);
    model_vec(384, 384, g_sc, em, ez);
    tests_run++; if (adiff(x_o, em) > 4) begin tests_failed++; $display("FAIL vec_diag_mag: got %0d want %0d", x_o, em); end
    tests_run++; if (adiff(z_o, ez) > 4) begin tests_failed++; $display("FAIL vec_diag_phase: got %0d want %0d", z_o, ez); end
  endtask

  task automatic test_noscale();
    int lat, ex, ey, rx, ry;
    run_op(1'b0, 128, 0, 0, lat);
    model_rot(128, 0, 0, g_raw, rx, ry);
    model_rot(128, 0, 0, g_sc, ex, ey);
    tests_run++; if (done_r !== 1'b1) begin tests_failed++; $display("FAIL raw_done: got %b want 1", done_r); end
    tests_run++; if (adiff(xr_o, rx) > 4) begin tests_failed++; $display("FAIL raw_x: got %0d want %0d", xr_o, rx); end
    tests_run++; if (adiff(yr_o, ry) > 4) begin tests_failed++; $display("FAIL raw_y: got %0d want %0d", yr_o, ry); end
    tests_run++; if (adiff(x_o, ex) > 4) begin tests_failed++; $display("FAIL scaled_x: got %0d want %0d", x_o, ex); end
  endtask

  task automatic test_saturation();
    int lat, ex, ey, tol;
    run_op(1'b0, 32767, 32767, 6434, lat);
    model_rot(32767, 32767, 6434, g_sc, ex, ey);
    // A residual angle of up to 5 units moves x by ~|v|*5/8192.
    tol = 4 + rnd(46341.0 * 5.0 / ZS);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL sat_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (y_o !== 16'sd32767) begin tests_failed++; $display("FAIL sat_pos_y: got %0d want 32767", y_o); end
    tests_run++; if (adiff(x_o, ex) > tol) begin tests_failed++; $display("FAIL sat_pos_x: got %0d want %0d", x_o, ex); end
    tests_run++; if (yr_o !== 16'sd32767) begin tests_failed++; $display("FAIL sat_raw_y: got %0d want 32767", yr_o); end
    run_op(1'b0, -32768, -32768, 6434, lat);
    tests_run++; if (y_o !== -16'sd32768) begin tests_failed++; $display("FAIL sat_neg_y: got %0d want -32768", y_o); end
  endtask

  task automatic test_rotation_random();
    int lat, x, y, z, ex, ey, rx, ry;
    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(0, 4000)) - 2000;
      y = int'($urandom_range(0, 4000)) - 2000;
      z = int'($urandom_range(0, 51472)) - 25736;
      run_op(1'b0, x, y, z, lat);
      model_rot(x, y, z, g_sc, ex, ey);
      model_rot(x, y, z, g_raw, rx, ry);
      tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL rrot_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      tests_run++; if (adiff(x_o, ex) > 12 || adiff(y_o, ey) > 12) begin
        tests_failed++; $display("FAIL rrot_xy[%0d] in %0d,%0d,%0d: got %0d,%0d want %0d,%0d", i, x, y, z, x_o, y_o, ex, ey); end
      tests_run++; if (adiff(z_o, 0) > 4) begin tests_failed++; $display("FAIL rrot_z[%0d]: got %0d want 0", i, z_o); end
      tests_run++; if (adiff(xr_o, rx) > 16 || adiff(yr_o, ry) > 16) begin
        tests_failed++; $display("FAIL rrot_raw[%0d]: got %0d,%0d want %0d,%0d", i, xr_o, yr_o, rx, ry); end
    end
  endtask

  task automatic test_vectoring_random();
    int lat, x, y, em, ez;
    for (int i = 0; i < 20; i++) begin
      do begin
        x = int'($urandom_range(0, 6000)) - 3000;
        y = int'($urandom_range(0, 6000)) - 3000;
      end while (x * x + y * y < 1500 * 1500);
      run_op(1'b1, x, y, int'($urandom_range(0, 20000)), lat);
      model_vec(x, y, g_sc, em, ez);
      tests_run++; if (adiff(x_o, em) > 12) begin tests_failed++; $display("FAIL rvec_mag[%0d] in %0d,%0d: got %0d want %0d", i, x, y, x_o, em); end
      tests_run++; if (adiff(y_o, 0) > 12) begin tests_failed++; $display("FAIL rvec_y[%0d]: got %0d want 0", i, y_o); end
      tests_run++; if (adiff(z_o, ez) > 24) begin tests_failed++; $display("FAIL rvec_phase[%0d] in %0d,%0d: got %0d want %0d", i, x, y, z_o, ez); end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first, ex, ey;
    mode_i = 1'b0; x_i = 16'sd1000; y_i = -16'sd700; z_i = 16'sd4000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    mode_i = 1'b1; x_i = -16'sd2000; y_i = 16'sd1500; z_i = -16'sd9000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first = 0;
    for (int e = 7; e <= 3 * LAT; e++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (first == 0) first = e; end
    end
    model_rot(1000, -700, 4000, g_sc, ex, ey);
    tests_run++; if (ndone !== 1) begin tests_failed++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
    tests_run++; if (first !== LAT) begin tests_failed++; $display("FAIL busy_done_edge: got %0d want %0d", first, LAT); end
    tests_run++; if (adiff(x_o, ex) > 12 || adiff(y_o, ey) > 12) begin
      tests_failed++; $display("FAIL busy_result: got %0d,%0d want %0d,%0d", x_o, y_o, ex, ey); end
  endtask

  task automatic test_back_to_back();
    int ndone, last, bad_gap, ready_idle;
    mode_i = 1'b0; x_i = 16'sd1000; y_i = 16'sd500; z_i = 16'sd3000; start = 1'b1;
    ndone = 0; last = 0; bad_gap = 0; ready_idle = 0;
    for (int e = 1; e <= 3 * LAT; e++) begin
      @(posedge clk); #1;
      if (done) begin
        if (e - last != LAT) bad_gap++;
        last = e; ndone++;
      end else if (ready) ready_idle++;
    end
    start = 1'b0;
    tests_run++; if (ndone !== 3) begin tests_failed++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
    tests_run++; if (bad_gap !== 0) begin tests_failed++; $display("FAIL b2b_interval: got %0d bad gaps want 0", bad_gap); end
    tests_run++; if (ready_idle !== 0) begin tests_failed++; $display("FAIL b2b_ready_low: got %0d ready cycles want 0", ready_idle); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, ndone, ex, ey;
    mode_i = 1'b0; x_i = 16'sd900; y_i = 16'sd300; z_i = 16'sd7000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async_ctrl: got ready %b done %b want 1 0", ready, done); end
    tests_run++; if (x_o !== 16'sd0 || y_o !== 16'sd0 || z_o !== 16'sd0) begin
      tests_failed++; $display("FAIL rst_async_out: got %0d %0d %0d want 0 0 0", x_o, y_o, z_o); end
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (2 * LAT) begin @(posedge clk); #1; if (done) ndone++; end
    tests_run++; if (ndone !== 0) begin tests_failed++; $display("FAIL rst_no_done: got %0d pulses want 0", ndone); end
    run_op(1'b0, 300, -200, 5000, lat);
    model_rot(300, -200, 5000, g_sc, ex, ey);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL rst_fresh_latency: got %0d want %0d", lat, LAT); end
    tests_run++; if (adiff(x_o, ex) > 4 || adiff(y_o, ey) > 4) begin
      tests_failed++; $display("FAIL rst_fresh_result: got %0d,%0d want %0d,%0d", x_o, y_o, ex, ey); end
  endtask

  initial begin
    g_raw = 1.0;
    for (int i = 0; i < ITERS; i++) g_raw = g_raw * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    g_sc = g_raw * 19898.0 / 32768.0;
    test_reset();
    test_rotation_basic();
    test_vectoring();
    test_noscale();
    test_saturation();
    test_rotation_random();
    test_vectoring_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
